// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared constants, index type and range helper for the IJVM register bank
package reg_bank_pkg;

    localparam int DEFAULT_WORD_WIDTH = 8;

    localparam int REG_OPC = 0;
    localparam int REG_H   = 1;
    localparam int REG_TOS = 2;
    localparam int REG_PC  = 3;

    typedef int unsigned idx_t;

    function automatic logic sel_in_range(input idx_t sel, input idx_t num_regs);
        return sel < num_regs;
    endfunction

endpackage

// File: rtl/reg_bank_reg_cell.sv
// rtl/reg_bank_reg_cell.sv - one datapath register with async reset, load and increment
module reg_cell
    import reg_bank_pkg::*;
#(
    parameter int                    WORD_WIDTH  = DEFAULT_WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] c_bus,
    input  logic                  wr_en,
    input  logic                  inc_en,
    output logic [WORD_WIDTH-1:0] value
);

    logic [WORD_WIDTH-1:0] value_d;
    logic [WORD_WIDTH-1:0] value_q;

    // A load wins over an increment; the increment wraps silently.
    always_comb begin
        value_d = value_q;
        if (wr_en) begin
            value_d = c_bus;
        end else if (inc_en) begin
            value_d = value_q + WORD_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= RESET_VALUE;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - bank of NUM_REGS registers loaded from the C bus, one driven onto the B bus
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int                    WORD_WIDTH  = DEFAULT_WORD_WIDTH,
    parameter int                    NUM_REGS    = 4,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0,
    localparam int                   SEL_WIDTH   = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] c_bus,
    input  logic [NUM_REGS-1:0]   c_write_enable,
    input  logic [NUM_REGS-1:0]   inc_enable,
    input  logic                  b_read_enable,
    input  logic [SEL_WIDTH-1:0]  b_sel,
    output logic [WORD_WIDTH-1:0] b_bus,
    output logic                  b_sel_err
);

    logic [WORD_WIDTH-1:0] regs [NUM_REGS];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        reg_cell #(
            .WORD_WIDTH  (WORD_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .c_bus  (c_bus),
            .wr_en  (c_write_enable[g]),
            .inc_en (inc_enable[g]),
            .value  (regs[g])
        );
    end

    logic                  sel_ok;
    logic [WORD_WIDTH-1:0] sel_data;
    logic                  drive_d,   drive_q;
    logic [WORD_WIDTH-1:0] bus_d,     bus_q;
    logic                  sel_err_d, sel_err_q;

    // Data is forced to zero when not driving so no stale or unknown value sits behind the enable.
    always_comb begin
        sel_ok   = sel_in_range(idx_t'(b_sel), idx_t'(NUM_REGS));
        sel_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_t'(b_sel) == idx_t'(i)) begin
                sel_data = regs[i];
            end
        end
        drive_d   = b_read_enable && sel_ok;
        sel_err_d = b_read_enable && !sel_ok;
        bus_d     = drive_d ? sel_data : '0;
    end

    // Falling-edge update keeps the B bus stable across the rising edge where the ALU samples it.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            drive_q   <= 1'b0;
            bus_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            drive_q   <= drive_d;
            bus_q     <= bus_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign b_bus     = drive_q ? bus_q : {WORD_WIDTH{1'bz}};
    assign b_sel_err = sel_err_q;

endmodule
